forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of source operands per instruction, valid 1..4.
REQ-002 Parameter REG_AW, default 5: register address width.
REQ-003 Parameter LOAD_LAT, default 1: load-use stall cycles, valid 1..3.
REQ-004 One clock and a synchronous, active-high reset, both listed first: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 id_src_addr  input  NUM_SRC*REG_AW: ID-stage source register numbers; operand i occupies bits [i*REG_AW +: REG_AW].
REQ-006 id_src_used  input  NUM_SRC: bit i high when operand i is actually read.
REQ-007 ex_rd, ex_reg_write, ex_mem_read  input  REG_AW,1,1: EX-stage destination, write enable, load flag.
REQ-008 mem_rd, mem_reg_write  input  REG_AW,1: MEM-stage destination and write enable.
REQ-009 flush  input  1: squash of ID/EX contents (taken branch).
REQ-010 fwd_sel  output  2*NUM_SRC: registered EX-stage operand select; field i is bits [2i+:2]; 2'b10 = MEM result, 2'b01 = WB result, 2'b00 = register file.
REQ-011 stall  output  1: registered; holds PC and IF/ID and inserts a bubble into EX.

Function
REQ-012 Forwarding SHALL be resolved one cycle early: on each rising edge fwd_sel is loaded from ID-stage operands compared against producers that will sit in MEM/WB when that instruction reaches EX.
REQ-013 Field i SHALL load 2'b10 when ex_reg_write=1, ex_rd!=0, ex_rd==src_i, id_src_used[i]=1.
REQ-014 Otherwise field i SHALL load 2'b01 when mem_reg_write=1, mem_rd!=0, mem_rd==src_i, id_src_used[i]=1.
REQ-015 Otherwise field i SHALL load 2'b00; EX match has priority over MEM match.
REQ-016 Load-use hazard: ex_mem_read=1, ex_reg_write=1, ex_rd!=0, ex_rd matches any used source.
REQ-017 FSM states IDLE and STALL with a 2-bit down-counter.
REQ-018 IDLE: hazard SHALL set stall=1 on the next edge, counter=LOAD_LAT-1, go to STALL; else stay IDLE with stall=0.
REQ-019 STALL: counter>0 SHALL decrement, keep stall=1; counter==0 SHALL clear stall and return to IDLE.
REQ-020 On any edge where stall is loaded 1, all fwd_sel fields SHALL load 2'b00 (a bubble enters EX).
REQ-021 During STALL, hazard inputs SHALL be ignored; on the release edge fwd_sel SHALL follow REQ-013..015, so with LOAD_LAT=1 the load result is forwarded as 2'b01.
REQ-022 flush=1 SHALL take priority over all else: next edge forces IDLE, stall=0, counter=0, fwd_sel all 2'b00.
REQ-023 Register 0 SHALL never be forwarded nor cause a stall.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, counter=0, stall=0, fwd_sel=0, stall_count=0 (if present); priority over flush.
REQ-025 Reset mid-STALL SHALL abandon the stall immediately, with no pending stall cycles afterwards.

Configuration
REQ-026 Macro HAZARD_STATS_EN: when defined, adds output stall_count (16 bits), which increments on every edge where stall is loaded 1 and saturates at 16'hFFFF.
REQ-027 Without HAZARD_STATS_EN the port and its counter SHALL be absent, with no other behavioural change.

Verification
REQ-028 NUM_SRC=2: ex_reg_write=1, ex_rd=3, src0=3, src1=4, mem_reg_write=1, mem_rd=4 -> next edge fwd_sel=4'b0110.
REQ-029 ex_rd=5, mem_rd=5, both writing, src0=5 -> field0=2'b10 (EX priority); ex_rd=0 with src0=0 -> 2'b00.
REQ-030 LOAD_LAT=1: load ex_rd=7, src1=7 used -> stall=1 one cycle, fwd_sel=0 during it; release edge field1=2'b01.
REQ-031 LOAD_LAT=3: same hazard -> stall high exactly 3 cycles; id_src_used[1]=0 -> no stall.
REQ-032 flush asserted in 2nd stall cycle -> next edge stall=0, fwd_sel=0; rst in STALL -> all outputs 0 next edge.
REQ-033 HAZARD_STATS_EN defined: 4 single-cycle load-use events -> stall_count=4; preloaded to 16'hFFFF, further stalls keep it 16'hFFFF.

Source files
------------

// File: rtl/forward_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : forward_hazard_unit_if
// Purpose  : Bundles the ID/EX/MEM pipeline signals the forwarding/hazard
//            unit observes, together with the operand selects and stall
//            request it returns.
// Ports    : master - pipeline side: drives the stage info, receives
//                     fwd_sel and stall.
//            slave  - hazard unit side: the reverse directions.
//            id_src_addr  [NUM_SRC*REG_AW] ID source register numbers
//            id_src_used  [NUM_SRC]        operand actually read
//            ex_rd / ex_reg_write / ex_mem_read   EX-stage producer
//            mem_rd / mem_reg_write               MEM-stage producer
//            flush                                squash ID/EX (taken branch)
//            fwd_sel [2*NUM_SRC]                  registered operand selects
//            stall                                registered stall/bubble
// Revision : 1.0 - initial release
// ============================================================================
interface forward_hazard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_reg_write;
    logic                      flush;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall;

    modport master (
        output id_src_addr, id_src_used, ex_rd, ex_reg_write, ex_mem_read,
        output mem_rd, mem_reg_write, flush,
        input  fwd_sel, stall
    );

    modport slave (
        input  id_src_addr, id_src_used, ex_rd, ex_reg_write, ex_mem_read,
        input  mem_rd, mem_reg_write, flush,
        output fwd_sel, stall
    );
endinterface
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_hazard_unit
// Purpose  : Early-resolved data forwarding and load-use stall control.
//            Operand selects for the instruction entering EX are computed
//            while it is still in ID, by comparing its sources with the
//            producers currently in EX and MEM (which will sit in MEM and WB
//            one cycle later).
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - forward_hazard_unit_if.slave (stage info in, fwd_sel and
//                   stall out)
//            stall_count [16] - saturating count of stall-loading edges
//                   (present only when HAZARD_STATS_EN is defined)
// Config   : `define HAZARD_STATS_EN to add the stall_count statistics port.
// Revision : 1.0 - initial release
// ============================================================================
module forward_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    forward_hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]          stall_count
`endif
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_STALL    = 1'b1;
    // Number of extra stall cycles after the first one.
    localparam logic [1:0] c_CNT_INIT = 2'(LOAD_LAT - 1);

    logic [0:0]           r_state;
    logic [1:0]           r_cnt;
    logic                 r_stall;
    logic [2*NUM_SRC-1:0] r_fwd_sel;

    logic [0:0]           w_state_nxt;
    logic [1:0]           w_cnt_nxt;
    logic                 w_stall_nxt;
    logic [2*NUM_SRC-1:0] w_fwd_nxt;

    logic [NUM_SRC-1:0]   w_ex_hit;
    logic [NUM_SRC-1:0]   w_mem_hit;
    logic [2*NUM_SRC-1:0] w_fwd_calc;
    logic                 w_ex_valid;
    logic                 w_mem_valid;
    logic                 w_hazard;

    // Register 0 is hard-wired zero, so a write to it never produces data.
    assign w_ex_valid  = bus.ex_reg_write  && (bus.ex_rd  != '0);
    assign w_mem_valid = bus.mem_reg_write && (bus.mem_rd != '0);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] w_src;
        assign w_src         = bus.id_src_addr[gi*REG_AW +: REG_AW];
        assign w_ex_hit[gi]  = bus.id_src_used[gi] && w_ex_valid  && (bus.ex_rd  == w_src);
        assign w_mem_hit[gi] = bus.id_src_used[gi] && w_mem_valid && (bus.mem_rd == w_src);
        // The younger producer (now in EX, next in MEM) holds the newest value.
        assign w_fwd_calc[2*gi +: 2] = w_ex_hit[gi]  ? 2'b10 :
                                       w_mem_hit[gi] ? 2'b01 : 2'b00;
    end

    // A load in EX cannot supply its data until it leaves MEM.
    assign w_hazard = bus.ex_mem_read && (|w_ex_hit);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_nxt = 1'b0;
        w_fwd_nxt   = w_fwd_calc;

        if (bus.flush) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = 2'd0;
            w_fwd_nxt   = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hazard) begin
                        w_state_nxt = c_STALL;
                        w_cnt_nxt   = c_CNT_INIT;
                        w_stall_nxt = 1'b1;
                        w_fwd_nxt   = '0;
                    end
                end
                c_STALL: begin
                    // Hazard inputs are not examined here; the stalled
                    // instruction is re-evaluated only on the release edge.
                    if (r_cnt != 2'd0) begin
                        w_cnt_nxt   = r_cnt - 2'd1;
                        w_stall_nxt = 1'b1;
                        w_fwd_nxt   = '0;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 2'd0;
                    w_fwd_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 2'd0;
            r_stall   <= 1'b0;
            r_fwd_sel <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stall   <= w_stall_nxt;
            r_fwd_sel <= w_fwd_nxt;
        end
    end

    assign bus.fwd_sel = r_fwd_sel;
    assign bus.stall   = r_stall;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 16'd0;
        end else if (w_stall_nxt && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_forward_hazard_unit
// Purpose  : Directed self-checking bench. Two instances share stimulus:
//            dut_l1 (LOAD_LAT=1) and dut_l3 (LOAD_LAT=3), NUM_SRC=2,
//            REG_AW=5. Each check compares {stall, fwd_sel} (5 bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    forward_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) bus1 ();
    forward_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) bus3 ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count1;
    logic [15:0] stall_count3;
`endif

    forward_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1)) dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count1)
`endif
    );

    forward_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(3)) dut_l3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count3)
`endif
    );

    // ---------------- stimulus helpers (drive both instances) --------------
    task automatic set_ops(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used);
        bus1.id_src_addr = {s1, s0}; bus3.id_src_addr = {s1, s0};
        bus1.id_src_used = used;     bus3.id_src_used = used;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic rw, input logic mr);
        bus1.ex_rd = rd; bus1.ex_reg_write = rw; bus1.ex_mem_read = mr;
        bus3.ex_rd = rd; bus3.ex_reg_write = rw; bus3.ex_mem_read = mr;
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic rw);
        bus1.mem_rd = rd; bus1.mem_reg_write = rw;
        bus3.mem_rd = rd; bus3.mem_reg_write = rw;
    endtask

    task automatic set_flush(input logic f);
        bus1.flush = f; bus3.flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        set_ops(5'd4, 5'd3, 2'b11); set_ex(5'd3, 1'b1, 1'b1); set_mem(5'd4, 1'b1); set_flush(1'b0);
        rst = 1'b1; tick(); tick();
        n_checks++; if ({bus1.stall, bus1.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL reset_l1: got %b expected %b", {bus1.stall, bus1.fwd_sel}, 5'b0_0000); end
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL reset_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0000); end
        set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        // {s1, s0, used, ex_rd, ex_rw, ex_mr, mem_rd, mem_rw, expected}
        logic [4:0] s1 [5] = '{5'd4, 5'd9, 5'd0, 5'd6, 5'd3};
        logic [4:0] s0 [5] = '{5'd3, 5'd5, 5'd0, 5'd3, 5'd3};
        logic [1:0] us [5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
        logic [4:0] er [5] = '{5'd3, 5'd5, 5'd0, 5'd3, 5'd3};
        logic       ew [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       em [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0] mr [5] = '{5'd4, 5'd5, 5'd0, 5'd6, 5'd3};
        logic       mw [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] ex [5] = '{5'b0_0110, 5'b0_0010, 5'b0_0000, 5'b0_0100, 5'b0_0101};
        for (int i = 0; i < 5; i++) begin
            set_ops(s1[i], s0[i], us[i]); set_ex(er[i], ew[i], em[i]); set_mem(mr[i], mw[i]);
            tick();
            n_checks++; if ({bus1.stall, bus1.fwd_sel} !== ex[i]) begin n_fail++; $display("FAIL fwd_vec%0d_l1: got %b expected %b", i, {bus1.stall, bus1.fwd_sel}, ex[i]); end
            n_checks++; if ({bus3.stall, bus3.fwd_sel} !== ex[i]) begin n_fail++; $display("FAIL fwd_vec%0d_l3: got %b expected %b", i, {bus3.stall, bus3.fwd_sel}, ex[i]); end
        end
    endtask

    task automatic test_load_use();
        // Load to r7 in EX, ID reads r7 on operand 1; bubble follows the load.
        logic [4:0] e1 [4] = '{5'b1_0000, 5'b0_0100, 5'b0_0100, 5'b0_0100};
        logic [4:0] e3 [4] = '{5'b1_0000, 5'b1_0000, 5'b1_0000, 5'b0_0100};
        do_reset();
        set_ops(5'd7, 5'd2, 2'b10); set_ex(5'd7, 1'b1, 1'b1); set_mem(5'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) begin set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd7, 1'b1); end
            n_checks++; if ({bus1.stall, bus1.fwd_sel} !== e1[c]) begin n_fail++; $display("FAIL loaduse_c%0d_l1: got %b expected %b", c, {bus1.stall, bus1.fwd_sel}, e1[c]); end
            n_checks++; if ({bus3.stall, bus3.fwd_sel} !== e3[c]) begin n_fail++; $display("FAIL loaduse_c%0d_l3: got %b expected %b", c, {bus3.stall, bus3.fwd_sel}, e3[c]); end
        end
    endtask

    task automatic test_hazard_held();
        // Hazard inputs held throughout: ignored while stalling, so release
        // forwards from EX (2'b10) and LOAD_LAT=1 re-stalls on the next edge.
        logic [4:0] e1 [4] = '{5'b1_0000, 5'b0_1000, 5'b1_0000, 5'b0_1000};
        logic [4:0] e3 [4] = '{5'b1_0000, 5'b1_0000, 5'b1_0000, 5'b0_1000};
        do_reset();
        set_ops(5'd7, 5'd2, 2'b10); set_ex(5'd7, 1'b1, 1'b1); set_mem(5'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if ({bus1.stall, bus1.fwd_sel} !== e1[c]) begin n_fail++; $display("FAIL held_c%0d_l1: got %b expected %b", c, {bus1.stall, bus1.fwd_sel}, e1[c]); end
            n_checks++; if ({bus3.stall, bus3.fwd_sel} !== e3[c]) begin n_fail++; $display("FAIL held_c%0d_l3: got %b expected %b", c, {bus3.stall, bus3.fwd_sel}, e3[c]); end
        end
        // Operand not read: no stall, no forwarding.
        do_reset();
        set_ops(5'd7, 5'd2, 2'b01);
        tick();
        n_checks++; if ({bus1.stall, bus1.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL unused_l1: got %b expected %b", {bus1.stall, bus1.fwd_sel}, 5'b0_0000); end
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL unused_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0000); end
    endtask

    task automatic test_flush();
        do_reset();
        set_ops(5'd7, 5'd2, 2'b10); set_ex(5'd7, 1'b1, 1'b1); set_mem(5'd0, 1'b0);
        tick();
        set_ex(5'd0, 1'b0, 1'b0);
        tick();
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b1_0000) begin n_fail++; $display("FAIL flush_pre_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b1_0000); end
        // Second stall cycle of dut_l3: flush with a MEM match present.
        set_flush(1'b1); set_mem(5'd7, 1'b1);
        tick();
        n_checks++; if ({bus1.stall, bus1.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL flush_l1: got %b expected %b", {bus1.stall, bus1.fwd_sel}, 5'b0_0000); end
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL flush_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0000); end
        set_flush(1'b0);
        tick();
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0100) begin n_fail++; $display("FAIL flush_post_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0100); end
        // Flush outranks a fresh hazard in IDLE.
        set_flush(1'b1); set_ex(5'd7, 1'b1, 1'b1);
        tick();
        n_checks++; if ({bus1.stall, bus1.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL flush_haz_l1: got %b expected %b", {bus1.stall, bus1.fwd_sel}, 5'b0_0000); end
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL flush_haz_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0000); end
        set_flush(1'b0); set_ex(5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_ops(5'd7, 5'd2, 2'b10); set_ex(5'd7, 1'b1, 1'b1); set_mem(5'd0, 1'b0);
        tick();
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b1_0000) begin n_fail++; $display("FAIL rstmid_pre_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b1_0000); end
        set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd7, 1'b1); set_flush(1'b1); rst = 1'b1;
        tick();
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0000) begin n_fail++; $display("FAIL rstmid_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0000); end
        rst = 1'b0; set_flush(1'b0);
        tick();
        n_checks++; if ({bus3.stall, bus3.fwd_sel} !== 5'b0_0100) begin n_fail++; $display("FAIL rstmid_post_l3: got %b expected %b", {bus3.stall, bus3.fwd_sel}, 5'b0_0100); end
        n_checks++; if ({bus1.stall, bus1.fwd_sel} !== 5'b0_0100) begin n_fail++; $display("FAIL rstmid_post_l1: got %b expected %b", {bus1.stall, bus1.fwd_sel}, 5'b0_0100); end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        do_reset();
        set_ops(5'd7, 5'd2, 2'b10); set_mem(5'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_ex(5'd7, 1'b1, 1'b1); tick();
            set_ex(5'd0, 1'b0, 1'b0); tick();
        end
        n_checks++; if (stall_count1 !== 16'd4) begin n_fail++; $display("FAIL stats_count: got %h expected %h", stall_count1, 16'd4); end
        force dut_l1.r_stall_count = 16'hFFFF;
        tick();
        release dut_l1.r_stall_count;
        set_ex(5'd7, 1'b1, 1'b1); tick();
        set_ex(5'd0, 1'b0, 1'b0); tick();
        n_checks++; if (stall_count1 !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %h expected %h", stall_count1, 16'hFFFF); end
    endtask
`endif

    initial begin
        set_ops(5'd0, 5'd0, 2'b00); set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd0, 1'b0); set_flush(1'b0);
        test_reset();
        test_forwarding();
        test_load_use();
        test_hazard_held();
        test_flush();
        test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
